// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch front end.
//   XLEN             - machine word width
//   RESET_PC_DEFAULT - default first fetch address after reset
//   fetch_state_e    - fetch FSM state encoding
//   ibuf_entry_t     - one instruction buffer entry {pc, ir}
//   word_align()     - clears the byte-offset bits of an address
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StFlush
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } ibuf_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO sitting between fetch and decode.
//   clk, reset    - clock, synchronous active-low reset
//   flush_i       - drop all entries (wins over push/pop)
//   push_i        - write push_entry_i at the tail (ignored when full)
//   push_entry_i  - {pc, ir} to store
//   pop_i         - remove the head entry (ignored when empty)
//   head_o        - current head entry
//   count_o       - number of valid entries (0..2)
module fetch_buf
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        push_i,
    input  ibuf_entry_t push_entry_i,
    input  logic        pop_i,
    output ibuf_entry_t head_o,
    output logic [1:0]  count_o
);

    ibuf_entry_t entry_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        push_ok, pop_ok;

    assign push_ok = push_i && !flush_i && (count_q != 2'd2);
    assign pop_ok  = pop_i && !flush_i && (count_q != 2'd0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                entry_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign head_o  = entry_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: issues one word request at a time to instruction
// memory, buffers responses in a 2-entry FIFO and hands them to decode.
//   clk, reset      - clock, synchronous active-low reset
//   imem_req_o      - fetch request valid
//   imem_addr_o     - word-aligned fetch address
//   imem_ready_i    - memory accepts the request this cycle
//   imem_valid_i    - response valid
//   imem_data_i     - response instruction word
//   ir_o, pc_o      - head instruction and its PC
//   ir_valid_o      - head entry valid
//   ir_ready_i      - decode consumes the head this cycle
//   redirect_i      - branch/jump redirect
//   redirect_pc_i   - redirect target (byte offset ignored)
module fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] ir_o,
    output logic [XLEN-1:0] pc_o,
    output logic            ir_valid_o,
    input  logic            ir_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam logic [1:0] BufFull = 2'(BUF_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            outstanding_q, outstanding_d;

    logic            buf_push, buf_pop;
    logic [1:0]      buf_count;
    ibuf_entry_t     buf_head, push_entry;
    logic            rsp_accept;
    logic [2:0]      post_count;

    // A response only counts if it answers the single live request.
    assign rsp_accept = imem_valid_i && outstanding_q;
    assign buf_pop    = ir_valid_o && ir_ready_i;
    assign post_count = {1'b0, buf_count} + 3'd1 - {2'b00, buf_pop};
    assign push_entry = '{pc: req_addr_q, ir: imem_data_i};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        imem_req_o    = 1'b0;
        buf_push      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (buf_count != BufFull) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    state_d       = StWait;
                    outstanding_d = 1'b1;
                    req_addr_d    = word_align(fetch_pc_q);
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                end
            end
            StWait: begin
                if (rsp_accept) begin
                    buf_push      = 1'b1;
                    outstanding_d = 1'b0;
                    state_d       = (post_count < {1'b0, BufFull}) ? StReq : StIdle;
                end
            end
            StFlush: begin
                if (rsp_accept) begin
                    outstanding_d = 1'b0;
                    state_d       = StReq;
                end
            end
        endcase

        // Redirect overrides the normal flow: nothing fetched from the old
        // path may reach the buffer, and any live request is left to drain
        // in StFlush.
        if (redirect_i) begin
            buf_push   = 1'b0;
            fetch_pc_d = word_align(redirect_pc_i);
            unique case (state_q)
                StIdle:  state_d = StReq;
                StReq:   state_d = imem_ready_i ? StFlush : StReq;
                StWait:  state_d = rsp_accept ? StReq : StFlush;
                // A response landing together with the redirect ends the
                // drain; staying in StFlush would wait for a reply that
                // never comes.
                StFlush: state_d = rsp_accept ? StReq : StFlush;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            req_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_buf u_buf (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_i),
        .push_i       (buf_push),
        .push_entry_i (push_entry),
        .pop_i        (buf_pop),
        .head_o       (buf_head),
        .count_o      (buf_count)
    );

    assign imem_addr_o = word_align(fetch_pc_q);
    assign ir_o        = buf_head.ir;
    assign pc_o        = buf_head.pc;
    assign ir_valid_o  = (buf_count != 2'd0);

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch with a responding memory model and a scoreboard
// of expected {pc, ir} pairs checked as decode consumes them.
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req_o, imem_ready_i, imem_valid_i;
    logic [31:0] imem_addr_o, imem_data_i;
    logic [31:0] ir_o, pc_o, redirect_pc_i;
    logic        ir_valid_o, ir_ready_i, redirect_i;

    fetch #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_valid_i  (imem_valid_i),
        .imem_data_i   (imem_data_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .ir_valid_o    (ir_valid_o),
        .ir_ready_i    (ir_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] pop_log[$];
    int          total = 0;
    int          bad = 0;

    bit          cons_ready, mem_ready, redir;
    int          resp_lat;
    logic [31:0] redir_pc;
    bit          pend, pend_drop;
    logic [31:0] pend_addr;
    int          pend_wait;
    logic [31:0] exp_fetch;
    int          n_hs;
    logic [31:0] last_hs_addr;
    int          hs_start;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, model memory and decode,
    // then check ir_valid_o just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        ir_ready_i    = cons_ready;
        imem_ready_i  = mem_ready;
        imem_valid_i  = 1'b0;
        imem_data_i   = 32'hDEAD_BEEF;

        if (reset && !redir && ir_valid_o === 1'b1 && cons_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_ir_valid", 32'(ir_valid_o), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("ir_o", ir_o, e.ir);
                check("pc_o", pc_o, e.pc);
                pop_log.push_back(pc_o);
            end
        end

        if (pend) begin
            if (pend_wait == 0) begin
                imem_valid_i = 1'b1;
                imem_data_i  = mdata(pend_addr);
                pend         = 1'b0;
                if (reset && !redir && !pend_drop) begin
                    sbq.push_back('{pc: pend_addr, ir: mdata(pend_addr)});
                end
            end else begin
                pend_wait--;
            end
        end

        if (!reset || redir) begin
            sbq.delete();
            if (pend) pend_drop = 1'b1;
        end

        if (reset && imem_req_o === 1'b1 && mem_ready) begin
            check("imem_addr_o", imem_addr_o, exp_fetch);
            pend         = 1'b1;
            pend_addr    = exp_fetch;
            pend_wait    = resp_lat - 1;
            pend_drop    = redir;
            n_hs++;
            last_hs_addr = imem_addr_o;
            exp_fetch    = exp_fetch + 32'd4;
        end

        if (redir) exp_fetch = {redir_pc[31:2], 2'b00};
        if (!reset) exp_fetch = RST_PC;
        redir = 1'b0;

        @(posedge clk);
        #1;
        check("ir_valid_o", 32'(ir_valid_o), 32'(sbq.size() != 0));
    endtask

    task automatic wait_hs(input int limit);
        int start;
        start = n_hs;
        for (int i = 0; i < limit && n_hs == start; i++) cycle();
        if (n_hs == start) check("hs_timeout", 32'(n_hs), 32'(start + 1));
    endtask

    task automatic wait_pops(input int n, input int limit);
        for (int i = 0; i < limit && pop_log.size() < n; i++) cycle();
        if (pop_log.size() < n) check("pop_timeout", 32'(pop_log.size()), 32'(n));
    endtask

    initial begin
        reset = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ready_i = 1'b0; imem_valid_i = 1'b0; imem_data_i = '0; ir_ready_i = 1'b0;
        cons_ready = 1'b1; mem_ready = 1'b1; resp_lat = 1; redir = 1'b0; redir_pc = '0;
        pend = 1'b0; pend_drop = 1'b0; pend_addr = '0; pend_wait = 0;
        exp_fetch = RST_PC; n_hs = 0; last_hs_addr = '0;

        // Reset values and first-request timing
        cycle();
        cycle();
        check("rst_imem_req_o", 32'(imem_req_o), 32'd0);
        check("rst_imem_addr_o", imem_addr_o, RST_PC);
        check("rst_ir_valid_o", 32'(ir_valid_o), 32'd0);
        check("rst_ir_o", ir_o, 32'd0);
        check("rst_pc_o", pc_o, 32'd0);
        reset = 1'b1;
        cycle();
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_req_addr", imem_addr_o, RST_PC);

        // Streaming: 0,4,8 in order, then one request per two cycles
        pop_log.delete();
        wait_pops(3, 30);
        if (pop_log.size() >= 3) begin
            check("seq_pc0", pop_log[0], 32'h0);
            check("seq_pc1", pop_log[1], 32'h4);
            check("seq_pc2", pop_log[2], 32'h8);
        end
        hs_start = n_hs;
        repeat (20) cycle();
        check("throughput_hs", 32'(n_hs - hs_start), 32'd10);

        // Backpressure from reset: fill to 2, stall, drain, resume at 8
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cons_ready = 1'b0;
        pop_log.delete();
        hs_start = n_hs;
        repeat (10) cycle();
        check("full_model_count", 32'(sbq.size()), 32'd2);
        check("full_hs_count", 32'(n_hs - hs_start), 32'd2);
        check("full_req_idle", 32'(imem_req_o), 32'd0);
        check("full_head_pc", pc_o, RST_PC);
        cons_ready = 1'b1;
        wait_hs(20);
        check("resume_addr", last_hs_addr, 32'h8);
        wait_pops(2, 20);
        if (pop_log.size() >= 2) begin
            check("drain_pc0", pop_log[0], 32'h0);
            check("drain_pc1", pop_log[1], 32'h4);
        end

        // Redirect in WAIT before the response arrives
        resp_lat = 2;
        wait_hs(20);
        redir = 1'b1;
        redir_pc = 32'h0000_1003;
        cycle();
        check("flush_req_low", 32'(imem_req_o), 32'd0);
        cycle();
        check("redir_req", 32'(imem_req_o), 32'd1);
        check("redir_addr", imem_addr_o, 32'h0000_1000);
        pop_log.delete();
        wait_pops(1, 20);
        if (pop_log.size() >= 1) check("redir_first_pc", pop_log[0], 32'h0000_1000);

        // Redirect coincident with the response
        resp_lat = 1;
        wait_hs(20);
        redir = 1'b1;
        redir_pc = 32'h2000_0040;
        cycle();
        check("coinc_req", 32'(imem_req_o), 32'd1);
        check("coinc_addr", imem_addr_o, 32'h2000_0040);
        check("coinc_ir_valid", 32'(ir_valid_o), 32'd0);
        pop_log.delete();
        wait_pops(1, 20);
        if (pop_log.size() >= 1) check("coinc_first_pc", pop_log[0], 32'h2000_0040);

        // Address wrap at the top of memory
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        cycle();
        wait_hs(20);
        check("wrap_addr_top", last_hs_addr, 32'hFFFF_FFFC);
        wait_hs(20);
        check("wrap_addr_zero", last_hs_addr, 32'h0000_0000);

        // Memory not ready: request held, then redirected while held
        mem_ready = 1'b0;
        repeat (3) cycle();
        check("hold_req", 32'(imem_req_o), 32'd1);
        check("hold_addr", imem_addr_o, exp_fetch);
        cycle();
        check("hold_addr_stable", imem_addr_o, exp_fetch);
        redir = 1'b1;
        redir_pc = 32'h0000_3008;
        cycle();
        check("hold_redir_req", 32'(imem_req_o), 32'd1);
        check("hold_redir_addr", imem_addr_o, 32'h0000_3008);
        mem_ready = 1'b1;
        wait_hs(20);
        check("hold_redir_hs", last_hs_addr, 32'h0000_3008);

        // Reset during WAIT; the stale response arrives after release
        resp_lat = 3;
        wait_hs(20);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        pop_log.delete();
        wait_pops(1, 30);
        if (pop_log.size() >= 1) check("post_reset_pc", pop_log[0], RST_PC);

        resp_lat = 1;
        repeat (10) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
